// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC level scheduler.
// Imported by the scheduler top and its rectifier.
package adc_pkg;

  localparam int BUS_WIDTH_DEF = 12;
  localparam int MID_SCALE = 2 ** (BUS_WIDTH_DEF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_UPDATE,
    S_REPORT
  } adc_sched_state_t;

  // A single channel still needs a 1-bit index.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/half_rectify.sv
// Half-wave rectifier about mid-scale.
// Codes at or below mid-scale map to zero.
module half_rectify
  import adc_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF
) (
  input  logic [BUS_WIDTH-1:0] din,
  output logic [BUS_WIDTH-1:0] mag
);

  assign mag = din[BUS_WIDTH-1]
             ? {1'b0, din[BUS_WIDTH-2:0]}
             : '0;

endmodule

// File: rtl/adc_level_scheduler.sv
// Round-robin ADC sample sequencer with per-channel
// windowed peak tracking and level reporting.
module adc_level_scheduler
  import adc_pkg::*;
#(
  parameter  int BUS_WIDTH = BUS_WIDTH_DEF,
  parameter  int CHANNELS  = 2,
  parameter  int WINDOW    = 256,
  localparam int CW        = chan_w(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic                 adc_req,
  output logic [CW-1:0]        adc_chan,
  input  logic                 adc_ack,
  input  logic [BUS_WIDTH-1:0] adc_data,
  output logic [BUS_WIDTH-1:0] level,
  output logic [CW-1:0]        level_chan,
  output logic                 level_valid,
  output logic                 busy
);

  localparam int RW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);
  localparam logic [RW-1:0] LAST_RD = RW'(WINDOW - 1);

  adc_sched_state_t state;
  adc_sched_state_t nstate;

  logic [CW-1:0]        ch;
  logic [RW-1:0]        rnd;
  logic [CW-1:0]        rep;
  logic [CW-1:0]        rep_nx;
  logic [BUS_WIDTH-1:0] mag;
  logic [BUS_WIDTH-1:0] mag_q;
  logic [BUS_WIDTH-1:0] upd_val;
  logic [BUS_WIDTH-1:0] peak [CHANNELS];
  logic                 last_slot;
  logic                 rep_last;

  half_rectify #(
    .BUS_WIDTH(BUS_WIDTH)
  ) u_rect (
    .din(adc_data),
    .mag(mag)
  );

  assign last_slot = (ch == LAST_CH) && (rnd == LAST_RD);
  assign rep_last  = (rep == LAST_CH);
  assign rep_nx    = rep + 1'b1;
  assign upd_val   = (mag_q > peak[ch]) ? mag_q : peak[ch];

  assign adc_req  = (state == S_REQ);
  assign adc_chan = (state == S_REQ) ? ch : '0;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE: begin
        if (enable) nstate = S_REQ;
      end
      S_REQ: begin
        if (adc_ack) nstate = S_UPDATE;
      end
      S_UPDATE: begin
        if (last_slot)   nstate = S_REPORT;
        else if (enable) nstate = S_REQ;
        else             nstate = S_IDLE;
      end
      S_REPORT: begin
        if (rep_last) nstate = enable ? S_REQ : S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Level outputs load on the edge that enters each report slot,
  // so level_valid lines up with the REPORT state cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch          <= '0;
      rnd         <= '0;
      rep         <= '0;
      mag_q       <= '0;
      level       <= '0;
      level_chan  <= '0;
      level_valid <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) peak[i] <= '0;
    end else begin
      level_valid <= 1'b0;
      unique case (state)
        S_REQ: begin
          if (adc_ack) mag_q <= mag;
        end
        S_UPDATE: begin
          peak[ch] <= upd_val;
          if (last_slot) begin
            rep         <= '0;
            level       <= (ch == '0) ? upd_val : peak[0];
            level_chan  <= '0;
            level_valid <= 1'b1;
            peak[0]     <= '0;
          end else if (ch == LAST_CH) begin
            ch  <= '0;
            rnd <= rnd + 1'b1;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        S_REPORT: begin
          if (!rep_last) begin
            rep          <= rep_nx;
            level        <= peak[rep_nx];
            level_chan   <= rep_nx;
            level_valid  <= 1'b1;
            peak[rep_nx] <= '0;
          end else begin
            ch  <= '0;
            rnd <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_level_scheduler.sv
// Randomized self-checking bench for adc_level_scheduler.
// Reference model tracks slots, peaks and reports arithmetically.
module tb_adc_level_scheduler;

  localparam int BW  = 12;
  localparam int C   = 2;
  localparam int W   = 3;
  localparam int CW  = 1;
  localparam int MID = 2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          adc_req;
  logic [CW-1:0] adc_chan;
  logic          adc_ack;
  logic [BW-1:0] adc_data;
  logic [BW-1:0] level;
  logic [CW-1:0] level_chan;
  logic          level_valid;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int slot = 0;
  int m_peak [C];

  always #5 clk = ~clk;

  adc_level_scheduler #(
    .BUS_WIDTH(BW),
    .CHANNELS(C),
    .WINDOW(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .adc_req(adc_req),
    .adc_chan(adc_chan),
    .adc_ack(adc_ack),
    .adc_data(adc_data),
    .level(level),
    .level_chan(level_chan),
    .level_valid(level_valid),
    .busy(busy)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    slot = 0;
    for (int i = 0; i < C; i++) m_peak[i] = 0;
  endtask

  // One full request/ack transaction plus whatever follows it.
  task automatic do_sample(input int d, input int lat,
                           input bit en_after, input bit hold_ack,
                           input bit rep_drop);
    int n;
    int mg;
    int last;
    logic [CW-1:0] ech;
    if (!enable) begin
      enable = 1'b1;
      @(negedge clk);
      checks++;
      if (adc_req !== 1'b1) begin
        errors++;
        $display("FAIL enable_start: adc_req=%0b want 1", adc_req);
      end
    end
    n = 0;
    while (adc_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (adc_req !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout: adc_req=%0b want 1", adc_req);
      return;
    end
    ech = CW'(slot % C);
    checks++;
    if (adc_chan !== ech) begin
      errors++;
      $display("FAIL req_chan: got %0d want %0d", adc_chan, ech);
    end
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      checks++;
      if (adc_req !== 1'b1 || adc_chan !== ech) begin
        errors++;
        $display("FAIL req_hold: req=%0b chan=%0d want 1/%0d",
                 adc_req, adc_chan, ech);
      end
    end
    adc_ack  = 1'b1;
    adc_data = BW'(d);
    enable   = en_after;
    @(negedge clk);
    checks++;
    if (adc_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL update: req=%0b busy=%0b want 0/1",
               adc_req, busy);
    end
    if (hold_ack) adc_data = 12'hFFF;
    else          adc_ack  = 1'b0;
    mg = (d >= MID) ? d - MID : 0;
    if (mg > m_peak[slot % C]) m_peak[slot % C] = mg;
    if (slot == C * W - 1) begin
      last = 0;
      for (int r = 0; r < C; r++) begin
        @(negedge clk);
        adc_ack = 1'b0;
        if (rep_drop && r == 0) enable = 1'b0;
        checks++;
        if (level_valid !== 1'b1 || level_chan !== CW'(r) ||
            level !== BW'(m_peak[r])) begin
          errors++;
          $display("FAIL report: v=%0b ch=%0d lvl=%0d want 1/%0d/%0d",
                   level_valid, level_chan, level, r, m_peak[r]);
        end
        last = m_peak[r];
        m_peak[r] = 0;
      end
      slot = 0;
      @(negedge clk);
      checks++;
      if (level_valid !== 1'b0 || level !== BW'(last) ||
          level_chan !== CW'(C - 1)) begin
        errors++;
        $display("FAIL level_hold: v=%0b ch=%0d lvl=%0d want 0/%0d/%0d",
                 level_valid, level_chan, level, C - 1, last);
      end
    end else begin
      slot++;
      @(negedge clk);
      adc_ack = 1'b0;
    end
    checks++;
    if (adc_req !== enable || busy !== enable || level_valid !== 1'b0) begin
      errors++;
      $display("FAIL after: req=%0b busy=%0b v=%0b want %0b/%0b/0",
               adc_req, busy, level_valid, enable, enable);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    adc_ack = 1'b0;
    adc_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({adc_req, adc_chan, level, level_chan, level_valid, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%0b ch=%0d lvl=%0d lch=%0d v=%0b busy=%0b",
               adc_req, adc_chan, level, level_chan, level_valid, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %0b want 0", busy);
    end
    model_reset();
  endtask

  task automatic test_window_basic();
    int s [6] = '{3000, 1000, 2048, 2048, 2048, 2048};
    foreach (s[i]) do_sample(s[i], 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_peak_clear();
    int s [6] = '{2048, 2100, 4095, 2048, 2049, 2048};
    foreach (s[i]) do_sample(s[i], 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < C * W; i++) do_sample(2048, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_ack_delay();
    do_sample(3500, 5, 1'b1, 1'b0, 1'b0);
    do_sample(2600, 5, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_enable_drop();
    do_sample(3900, 2, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || adc_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: busy=%0b req=%0b want 0/0", busy, adc_req);
    end
    do_sample(2500, 1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_stray_ack();
    do_sample(2300, 0, 1'b0, 1'b0, 1'b0);
    adc_ack  = 1'b1;
    adc_data = 12'hFFF;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || adc_req !== 1'b0) begin
        errors++;
        $display("FAIL idle_ack: busy=%0b req=%0b want 0/0", busy, adc_req);
      end
    end
    adc_ack = 1'b0;
    do_sample(2200, 0, 1'b1, 1'b1, 1'b0);
    do_sample(2100, 1, 1'b1, 1'b1, 1'b0);
    while (slot != 0) do_sample(2048, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_report_enable_drop();
    while (slot != C * W - 1) do_sample(2800, 0, 1'b1, 1'b0, 1'b0);
    do_sample(3300, 0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_sample(4000, 0, 1'b1, 1'b0, 1'b0);
    do_sample(3800, 0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (adc_req !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_req: got %0b want 1", adc_req);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({adc_req, adc_chan, level, level_chan, level_valid, busy} !== '0) begin
      errors++;
      $display("FAIL mid_reset: req=%0b ch=%0d lvl=%0d lch=%0d v=%0b busy=%0b",
               adc_req, adc_chan, level, level_chan, level_valid, busy);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (adc_req !== 1'b1 || adc_chan !== '0 || level_valid !== 1'b0) begin
      errors++;
      $display("FAIL restart: req=%0b ch=%0d v=%0b want 1/0/0",
               adc_req, adc_chan, level_valid);
    end
    for (int i = 0; i < C * W; i++) do_sample(2048, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int d;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 4))
        0: d = 2048;
        1: d = 4095;
        2: d = $urandom_range(2040, 2056);
        default: d = $urandom_range(0, 4095);
      endcase
      do_sample(d, $urandom_range(0, 3),
                $urandom_range(0, 4) != 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    test_reset();
    test_window_basic();
    test_peak_clear();
    test_ack_delay();
    test_enable_drop();
    test_stray_ack();
    test_report_enable_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
